// File: rtl/pwm_multi_ch_engine.sv
// Multi-channel PWM / timer engine: edge or center-aligned counters, one-shot, sticky IRQs.
// Define PWM_SHADOW_EN to double-buffer period/duty; shadows load at each boundary or while idle.
module pwm_multi_ch_engine #(
   parameter int NCH = 4,
   parameter int CW  = 16
) (
   input  logic           selected_clk,
   input  logic           RST_I,
   input  logic           tick_en,
   input  logic           cfg_we,
   input  logic [3:0]     cfg_ch,
   input  logic [1:0]     cfg_sel,
   input  logic [CW-1:0]  cfg_wdata,
   input  logic [NCH-1:0] irq_clr,
   output logic [NCH-1:0] o_pwm,
   output logic [NCH-1:0] o_irq,
   output logic [NCH-1:0] o_run
);

   localparam logic [1:0] SEL_PERIOD = 2'd0;
   localparam logic [1:0] SEL_DUTY   = 2'd1;
   localparam logic [1:0] SEL_CTRL   = 2'd2;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE    = 1;
   localparam int CTRL_ALIGN   = 2;
   localparam int CTRL_ONESHOT = 3;
   localparam int CTRL_INV     = 4;

   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [4:0]    r_ctrl;
         logic [CW-1:0] r_period;
         logic [CW-1:0] r_duty;
         logic [CW-1:0] r_cnt;
         dir_t          r_dir;
         logic          r_run;
         logic          r_pwm;
         logic          r_irq;

         logic          w_hit;
         logic          w_wr_period;
         logic          w_wr_duty;
         logic          w_wr_ctrl;
         logic          w_active;
         logic          w_boundary;
         logic          w_pwm_next;
         logic [CW-1:0] w_cnt_next;
         dir_t          w_dir_next;

         assign w_hit       = cfg_we && (cfg_ch == 4'(gi));
         assign w_wr_period = w_hit && (cfg_sel == SEL_PERIOD);
         assign w_wr_duty   = w_hit && (cfg_sel == SEL_DUTY);
         assign w_wr_ctrl   = w_hit && (cfg_sel == SEL_CTRL);

         // o_run already drops on one-shot completion, so it gates the counter as well.
         assign w_active = r_ctrl[CTRL_EN] && r_run;

         always_comb begin
            w_cnt_next = r_cnt;
            w_dir_next = r_dir;
            w_boundary = 1'b0;
            if (!w_active || (r_period == '0)) begin
               w_cnt_next = '0;
               w_dir_next = DIR_UP;
            end else if (tick_en) begin
               if (!r_ctrl[CTRL_ALIGN]) begin
                  // >= also recovers when the period shrinks below the live count.
                  if (r_cnt >= (r_period - ONE)) begin
                     w_cnt_next = '0;
                     w_boundary = 1'b1;
                  end else begin
                     w_cnt_next = r_cnt + ONE;
                  end
               end else begin
                  unique case (r_dir)
                     DIR_UP: begin
                        if (r_cnt < r_period) begin
                           w_cnt_next = r_cnt + ONE;
                        end else if (r_period == ONE) begin
                           w_cnt_next = '0;
                           w_boundary = 1'b1;
                        end else begin
                           w_cnt_next = r_period - ONE;
                           w_dir_next = DIR_DOWN;
                        end
                     end
                     DIR_DOWN: begin
                        if (r_cnt <= ONE) begin
                           w_cnt_next = '0;
                           w_dir_next = DIR_UP;
                           w_boundary = 1'b1;
                        end else begin
                           w_cnt_next = r_cnt - ONE;
                        end
                     end
                  endcase
               end
            end
         end

         assign w_pwm_next = (w_active && r_ctrl[CTRL_MODE] && (r_period != '0) &&
                              (r_cnt < r_duty)) ^ r_ctrl[CTRL_INV];

         always_ff @(posedge selected_clk or negedge RST_I) begin
            if (!RST_I) begin
               r_ctrl <= '0;
               r_run  <= 1'b0;
               r_cnt  <= '0;
               r_dir  <= DIR_UP;
               r_pwm  <= 1'b0;
               r_irq  <= 1'b0;
            end else begin
               r_cnt <= w_cnt_next;
               r_dir <= w_dir_next;
               r_pwm <= w_pwm_next;
               if (w_wr_ctrl) begin
                  r_ctrl <= cfg_wdata[4:0];
                  r_run  <= cfg_wdata[CTRL_EN];
               end else if (w_boundary && r_ctrl[CTRL_ONESHOT]) begin
                  r_run <= 1'b0;
               end
               // A boundary on the same clock as a clear keeps the flag set.
               if (w_boundary) begin
                  r_irq <= 1'b1;
               end else if (irq_clr[gi]) begin
                  r_irq <= 1'b0;
               end
            end
         end

`ifdef PWM_SHADOW_EN
         logic [CW-1:0] r_period_sh;
         logic [CW-1:0] r_duty_sh;

         always_ff @(posedge selected_clk or negedge RST_I) begin
            if (!RST_I) begin
               r_period_sh <= '0;
               r_duty_sh   <= '0;
               r_period    <= '0;
               r_duty      <= '0;
            end else begin
               if (w_wr_period) begin
                  r_period_sh <= cfg_wdata;
               end
               if (w_wr_duty) begin
                  r_duty_sh <= cfg_wdata;
               end
               // Loads the pre-write shadow, so a write on a boundary clock waits for the next one.
               if (w_boundary || !w_active) begin
                  r_period <= r_period_sh;
                  r_duty   <= r_duty_sh;
               end
            end
         end
`else
         always_ff @(posedge selected_clk or negedge RST_I) begin
            if (!RST_I) begin
               r_period <= '0;
               r_duty   <= '0;
            end else begin
               if (w_wr_period) begin
                  r_period <= cfg_wdata;
               end
               if (w_wr_duty) begin
                  r_duty <= cfg_wdata;
               end
            end
         end
`endif

         assign o_pwm[gi] = r_pwm;
         assign o_irq[gi] = r_irq;
         assign o_run[gi] = r_run;
      end
   endgenerate

endmodule

// File: tb/tb_pwm_multi_ch_engine.sv
// Self-checking bench for pwm_multi_ch_engine: directed scenarios plus random traffic,
// compared every clock against a phase-based reference model (honours PWM_SHADOW_EN).
`timescale 1ns/1ps
module tb_pwm_multi_ch_engine;

   localparam int NCH = 4;
   localparam int CW  = 16;

   logic           selected_clk = 1'b0;
   logic           RST_I;
   logic           tick_en;
   logic           cfg_we;
   logic [3:0]     cfg_ch;
   logic [1:0]     cfg_sel;
   logic [CW-1:0]  cfg_wdata;
   logic [NCH-1:0] irq_clr;
   logic [NCH-1:0] o_pwm;
   logic [NCH-1:0] o_irq;
   logic [NCH-1:0] o_run;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: each running channel is described by its phase t within the
   // period (0 .. P-1 edge, 0 .. 2P-1 center); the count is derived from t.
   logic [4:0] m_ctrl [NCH];
   bit         m_run  [NCH];
   bit         m_irq  [NCH];
   bit         m_pwm  [NCH];
   int         m_p    [NCH];
   int         m_d    [NCH];
   int         m_p_sh [NCH];
   int         m_d_sh [NCH];
   int         m_t    [NCH];

   pwm_multi_ch_engine #(.NCH(NCH), .CW(CW)) dut (
      .selected_clk (selected_clk),
      .RST_I        (RST_I),
      .tick_en      (tick_en),
      .cfg_we       (cfg_we),
      .cfg_ch       (cfg_ch),
      .cfg_sel      (cfg_sel),
      .cfg_wdata    (cfg_wdata),
      .irq_clr      (irq_clr),
      .o_pwm        (o_pwm),
      .o_irq        (o_irq),
      .o_run        (o_run)
   );

   always #5 selected_clk = ~selected_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic int count_of(input int c);
      int p;
      int pos;
      p = m_p[c];
      if (p == 0) return 0;
      if (!m_ctrl[c][2]) return m_t[c] % p;
      pos = m_t[c] % (2 * p);
      return (pos <= p) ? pos : (2 * p - pos);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_ctrl[c] = '0;
         m_run[c]  = 1'b0;
         m_irq[c]  = 1'b0;
         m_pwm[c]  = 1'b0;
         m_p[c]    = 0;
         m_d[c]    = 0;
         m_p_sh[c] = 0;
         m_d_sh[c] = 0;
         m_t[c]    = 0;
      end
   endtask

   task automatic model_step();
      if (!RST_I) begin
         model_reset();
         return;
      end
      for (int c = 0; c < NCH; c++) begin
         bit act;
         bit bnd;
         bit wr;
         int plen;
         act  = m_run[c];
         plen = m_ctrl[c][2] ? 2 * m_p[c] : m_p[c];
         bnd  = act && (m_p[c] != 0) && tick_en && (m_t[c] + 1 == plen);
         wr   = cfg_we && (int'(cfg_ch) == c);

         m_pwm[c] = (act && m_ctrl[c][1] && (m_p[c] != 0) && (count_of(c) < m_d[c]))
                    ^ m_ctrl[c][4];
         if (!act || (m_p[c] == 0)) m_t[c] = 0;
         else if (tick_en)          m_t[c] = bnd ? 0 : m_t[c] + 1;

         if (bnd)             m_irq[c] = 1'b1;
         else if (irq_clr[c]) m_irq[c] = 1'b0;

`ifdef PWM_SHADOW_EN
         if (bnd || !act) begin
            m_p[c] = m_p_sh[c];
            m_d[c] = m_d_sh[c];
         end
         if (wr && cfg_sel == 2'd0) m_p_sh[c] = int'(cfg_wdata);
         if (wr && cfg_sel == 2'd1) m_d_sh[c] = int'(cfg_wdata);
`else
         if (wr && cfg_sel == 2'd0) m_p[c] = int'(cfg_wdata);
         if (wr && cfg_sel == 2'd1) m_d[c] = int'(cfg_wdata);
`endif
         if (wr && cfg_sel == 2'd2) begin
            m_ctrl[c] = cfg_wdata[4:0];
            m_run[c]  = cfg_wdata[0];
         end else if (bnd && m_ctrl[c][3]) begin
            m_run[c] = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      logic [NCH-1:0] e_pwm;
      logic [NCH-1:0] e_irq;
      logic [NCH-1:0] e_run;
      for (int c = 0; c < NCH; c++) begin
         e_pwm[c] = m_pwm[c];
         e_irq[c] = m_irq[c];
         e_run[c] = m_run[c];
      end
      check_val("o_pwm", 32'(o_pwm), 32'(e_pwm));
      check_val("o_irq", 32'(o_irq), 32'(e_irq));
      check_val("o_run", 32'(o_run), 32'(e_run));
   endtask

   task automatic cycle();
      @(posedge selected_clk);
      model_step();
      @(negedge selected_clk);
      check_outputs();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic cfg_write(input int ch, input int sel, input int data);
      cfg_we    = 1'b1;
      cfg_ch    = 4'(ch);
      cfg_sel   = 2'(sel);
      cfg_wdata = CW'(data);
      cycle();
      cfg_we    = 1'b0;
   endtask

   task automatic count_high(input int ch, input int n, output int ones);
      ones = 0;
      repeat (n) begin
         cycle();
         ones += int'(o_pwm[ch]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      int waited;
      RST_I     = 1'b0;
      tick_en   = 1'b1;
      cfg_we    = 1'b0;
      cfg_ch    = '0;
      cfg_sel   = '0;
      cfg_wdata = '0;
      irq_clr   = '0;
      model_reset();

      run(3);
      check_val("rst_pwm", 32'(o_pwm), 0);
      check_val("rst_irq", 32'(o_irq), 0);
      check_val("rst_run", 32'(o_run), 0);
      RST_I = 1'b1;
      run(2);

      // Edge PWM: P=10, D=3.
      cfg_write(0, 0, 10);
      cfg_write(0, 1, 3);
      cfg_write(0, 2, 'h03);
      run(20);
      count_high(0, 10, ones);
      check_val("edge_high_of_10", 32'(ones), 3);
      check_val("edge_irq_set", 32'(o_irq[0]), 1);

      // Center PWM: P=4, D=2 -> counts 0,1 and 1 of every 8 are high.
      cfg_write(1, 0, 4);
      cfg_write(1, 1, 2);
      cfg_write(1, 2, 'h07);
      run(16);
      count_high(1, 8, ones);
      check_val("center_high_of_8", 32'(ones), 3);

      // Timer one-shot: P=5.
      cfg_write(2, 0, 5);
      cfg_write(2, 2, 'h09);
      run(15);
      check_val("oneshot_run", 32'(o_run[2]), 0);
      check_val("oneshot_irq", 32'(o_irq[2]), 1);
      irq_clr = 4'b0100;
      cycle();
      irq_clr = '0;
      run(12);
      check_val("oneshot_no_rearm", 32'(o_irq[2]), 0);

      // Duty change mid-period on ch3.
      cfg_write(3, 0, 10);
      cfg_write(3, 1, 3);
      cfg_write(3, 2, 'h03);
      run(14);
      cfg_write(3, 1, 7);
      run(25);
      count_high(3, 10, ones);
      check_val("duty_update_high", 32'(ones), 7);

      // Duty extremes on ch0.
      cfg_write(0, 1, 0);
      run(20);
      count_high(0, 10, ones);
      check_val("duty0_high", 32'(ones), 0);
      cfg_write(0, 1, 12);
      run(20);
      count_high(0, 10, ones);
      check_val("duty_over_p_high", 32'(ones), 10);

      // P=0 on ch1: running but silent.
      cfg_write(1, 2, 'h00);
      cfg_write(1, 0, 0);
      cfg_write(1, 2, 'h03);
      irq_clr = 4'b0010;
      cycle();
      irq_clr = '0;
      run(25);
      check_val("p0_irq", 32'(o_irq[1]), 0);
      check_val("p0_pwm", 32'(o_pwm[1]), 0);

      // irq_clr held high on ch0: only the boundary clocks show the flag.
      irq_clr = 4'b0001;
      run(5);
      ones = 0;
      repeat (20) begin
         cycle();
         ones += int'(o_irq[0]);
      end
      irq_clr = '0;
      check_val("irq_set_wins_cnt", 32'(ones), 2);

      // Asynchronous reset during an active pulse.
      waited = 0;
      while (o_pwm[0] !== 1'b1 && waited < 20) begin
         cycle();
         waited++;
      end
      check_val("pulse_before_rst", 32'(o_pwm[0]), 1);
      #2;
      RST_I = 1'b0;
      #1;
      check_val("async_rst_pwm", 32'(o_pwm), 0);
      check_val("async_rst_irq", 32'(o_irq), 0);
      check_val("async_rst_run", 32'(o_run), 0);
      model_reset();
      cycle();
      RST_I = 1'b1;
      run(2);

      // Random traffic. Period writes only to idle channels and align kept while running,
      // so the phase model stays well-defined.
      for (int k = 0; k < 3000; k++) begin
         int ch;
         int sel;
         int data;
         tick_en = ($urandom_range(0, 3) != 0);
         irq_clr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
         cfg_we  = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            ch  = $urandom_range(0, 6);
            if (ch == 6) ch = 15;
            sel = $urandom_range(0, 3);
            if (ch < NCH && sel == 0 && m_run[ch]) sel = 1;
            case (sel)
               0:       data = $urandom_range(0, 9);
               1:       data = $urandom_range(0, 12);
               2:       data = $urandom_range(0, 31) | (($urandom_range(0, 2) != 0) ? 1 : 0);
               default: data = int'($urandom_range(0, 65535));
            endcase
            if (ch < NCH && sel == 2 && m_run[ch]) begin
               data = (data & ~4) | (int'(m_ctrl[ch][2]) << 2);
            end
            cfg_we    = 1'b1;
            cfg_ch    = 4'(ch);
            cfg_sel   = 2'(sel);
            cfg_wdata = CW'(data);
         end
         cycle();
      end
      cfg_we  = 1'b0;
      irq_clr = '0;
      tick_en = 1'b1;
      run(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
